sipo_deserializer: RTL and testbench

- Serial-to-parallel receiver; the receiving end of the MSB-first shift-register link used across retro_paint.
- Collects SHIFT_AMOUNT bits per in_SHIFT strobe into a WIDTH-bit accumulator and presents each completed word on a one-deep output register with a valid/ready handshake.
- Flags words lost because the consumer did not take the previous one.
- Typical uses: receiving serialized pixel/colour words and loopback-checking the transmit shifters.

---
 rtl/sipo_deserializer_pkg.sv | 28 ++
 rtl/sipo_deserializer_beat_counter.sv | 28 ++
 rtl/sipo_deserializer.sv | 90 +++++++++
 tb/tb_sipo_deserializer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sipo_deserializer_pkg.sv
// sipo_deserializer_pkg: shared sizing helpers and output-register state type for the serial link.
package sipo_deserializer_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int beats(input int width, input int shift_amount);
        return width / shift_amount;
    endfunction

    function automatic int count_width(input int width, input int shift_amount);
        return clog2(beats(width, shift_amount) + 1);
    endfunction

    function automatic bit shift_ok(input int width, input int shift_amount);
        return shift_amount > 0 && width >= shift_amount && width % shift_amount == 0;
    endfunction

endpackage

// File: rtl/sipo_deserializer_beat_counter.sv
// sipo_deserializer_beat_counter: modulo-BEATS beat counter; tc_o marks the beat that completes a word.
module sipo_deserializer_beat_counter #(
    parameter int BEATS = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          inc_i,
    output logic [CW-1:0] count_o,
    output logic          tc_o
);

    logic [CW-1:0] count_q, count_d;

    assign tc_o    = inc_i && count_q == CW'(BEATS - 1);
    assign count_o = count_q;

    always_comb begin
        count_d = clear_i ? '0 : tc_o ? '0 : inc_i ? count_q + 1'b1 : count_q;
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: collects serial beats into WIDTH-bit words on the falling clock edge and
// holds each finished word in a one-deep valid/ready output register with sticky overrun.
module sipo_deserializer
    import sipo_deserializer_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int SHIFT_AMOUNT = 1,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [SHIFT_AMOUNT-1:0]                       in_BIT,
    input  logic                                          in_SHIFT,
    input  logic                                          in_CLEAR,
    input  logic                                          in_READY,
    output logic [WIDTH-1:0]                              out_DATA,
    output logic                                          out_VALID,
    output logic                                          out_OVERRUN,
    output logic [count_width(WIDTH, SHIFT_AMOUNT)-1:0]   out_COUNT
);

    localparam int BEATS = beats(WIDTH, SHIFT_AMOUNT);
    localparam int CW    = count_width(WIDTH, SHIFT_AMOUNT);

    if (!shift_ok(WIDTH, SHIFT_AMOUNT)) begin : g_bad_cfg
        $error("WIDTH must be a non-zero multiple of SHIFT_AMOUNT");
    end

    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] shifted;
    logic             tc;
    logic             done;

    sipo_deserializer_beat_counter #(
        .BEATS (BEATS),
        .CW    (CW)
    ) u_beat_counter (
        .clk     (clk),
        .rst     (rst),
        .clear_i (in_CLEAR),
        .inc_i   (in_SHIFT),
        .count_o (out_COUNT),
        .tc_o    (tc)
    );

    if (BEATS == 1) begin : g_one
        assign shifted = in_BIT;
    end else if (MSB_FIRST) begin : g_msb
        assign shifted = {acc_q[WIDTH-1-SHIFT_AMOUNT:0], in_BIT};
    end else begin : g_lsb
        assign shifted = {in_BIT, acc_q[WIDTH-1:SHIFT_AMOUNT]};
    end

    // tc already includes in_SHIFT; a completed word is the shifted value on that edge
    assign done = tc && !in_CLEAR;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            acc_q   <= '0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = in_CLEAR         ? EMPTY :
                  state_q == EMPTY ? (done ? FULL : EMPTY) :
                  (done || !in_READY) ? FULL : EMPTY;
    end

    always_comb begin
        acc_d       = in_CLEAR || done ? '0 : in_SHIFT ? shifted : acc_q;
        data_d      = in_CLEAR ? '0 :
                      (done && (state_q == EMPTY || in_READY)) ? shifted : data_q;
        ovr_d       = !in_CLEAR && (ovr_q || (done && state_q == FULL && !in_READY));
        out_DATA    = data_q;
        out_VALID   = state_q == FULL;
        out_OVERRUN = ovr_q;
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: three deserializer configurations driven together and compared against a
// word-level reference model, with directed scenarios followed by random traffic.
module tb_sipo_deserializer;

    localparam int SA [3]  = '{1, 1, 2};
    localparam int MSB [3] = '{1, 0, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       shift = 1'b0, clear = 1'b0, ready = 1'b0;
    logic [0:0] bit1 = '0;
    logic [1:0] bit2 = '0;

    logic [7:0] d0, d1, d2;
    logic       v0, v1, v2, o0, o1, o2;
    logic [3:0] c0, c1;
    logic [2:0] c2;

    logic [7:0] o_data [3];
    logic       o_valid [3];
    logic       o_ovr [3];
    logic [3:0] o_cnt [3];

    int         m_cnt [3];
    logic [7:0] m_word [3];
    logic [7:0] m_data [3];
    logic       m_valid [3];
    logic       m_ovr [3];

    int n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(8), .SHIFT_AMOUNT(1), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in_BIT(bit1), .in_SHIFT(shift), .in_CLEAR(clear), .in_READY(ready),
        .out_DATA(d0), .out_VALID(v0), .out_OVERRUN(o0), .out_COUNT(c0));

    sipo_deserializer #(.WIDTH(8), .SHIFT_AMOUNT(1), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_BIT(bit1), .in_SHIFT(shift), .in_CLEAR(clear), .in_READY(ready),
        .out_DATA(d1), .out_VALID(v1), .out_OVERRUN(o1), .out_COUNT(c1));

    sipo_deserializer #(.WIDTH(8), .SHIFT_AMOUNT(2), .MSB_FIRST(1'b1)) u_sa2 (
        .clk(clk), .rst(rst), .in_BIT(bit2), .in_SHIFT(shift), .in_CLEAR(clear), .in_READY(ready),
        .out_DATA(d2), .out_VALID(v2), .out_OVERRUN(o2), .out_COUNT(c2));

    assign o_data  = '{d0, d1, d2};
    assign o_valid = '{v0, v1, v2};
    assign o_ovr   = '{o0, o1, o2};
    assign o_cnt   = '{c0, c1, {1'b0, c2}};

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_word[i] = '0; m_data[i] = '0; m_valid[i] = 1'b0; m_ovr[i] = 1'b0;
        end
    endtask

    // Word assembled positionally: beat k of a word occupies its final bit slot directly
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int nb, pos, b;
            logic done;
            logic [7:0] w;
            nb = 8 / SA[i];
            done = 1'b0;
            w = '0;
            if (clear) begin
                m_cnt[i] = 0; m_word[i] = '0; m_data[i] = '0; m_valid[i] = 1'b0; m_ovr[i] = 1'b0;
                continue;
            end
            if (shift) begin
                b = (i == 2) ? int'(bit2) : int'(bit1);
                pos = MSB[i] ? SA[i] * (nb - 1 - m_cnt[i]) : SA[i] * m_cnt[i];
                m_word[i] = m_word[i] | 8'(b << pos);
                m_cnt[i]++;
                if (m_cnt[i] == nb) begin
                    done = 1'b1; w = m_word[i]; m_cnt[i] = 0; m_word[i] = '0;
                end
            end
            if (!m_valid[i]) begin
                if (done) begin m_data[i] = w; m_valid[i] = 1'b1; end
            end else if (done && !ready) m_ovr[i] = 1'b1;
            else if (done) m_data[i] = w;
            else if (ready) m_valid[i] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("data%0d", i), int'(o_data[i]), int'(m_data[i]));
            chk($sformatf("valid%0d", i), int'(o_valid[i]), int'(m_valid[i]));
            chk($sformatf("ovr%0d", i), int'(o_ovr[i]), int'(m_ovr[i]));
            chk($sformatf("count%0d", i), int'(o_cnt[i]), m_cnt[i]);
        end
    endtask

    // Inputs change just after a rising edge; state updates on the following falling edge
    task automatic drive(input logic sh, input logic b1, input logic [1:0] b2, input logic rdy,
                         input logic clr);
        shift = sh; bit1 = b1; bit2 = b2; ready = rdy; clear = clr;
        model_step();
        @(negedge clk);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send8(input logic [7:0] v, input logic rdy);
        for (int i = 7; i >= 0; i--) drive(1'b1, v[i], 2'($urandom), rdy, 1'b0);
    endtask

    task automatic flush();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        clear = 1'b0;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_data", int'(d0), 0);
        chk("rst_valid", int'(v0), 0);
        chk("rst_count", int'(c0), 0);
        check_all();
        rst = 1'b1;

        flush();
        send8(8'hA5, 1'b0);
        chk("a5_data", int'(d0), 8'hA5);
        chk("a5_valid", int'(v0), 1);
        chk("a5_count", int'(c0), 0);
        chk("a5_ovr", int'(o0), 0);
        chk("a5_lsb", int'(d1), 8'hA5);

        flush();
        send8(8'hC0, 1'b0);
        chk("lsb_03", int'(d1), 8'h03);

        flush();
        send8(8'h3C, 1'b0);
        send8(8'hFF, 1'b0);
        chk("ovr_data", int'(d0), 8'h3C);
        chk("ovr_flag", int'(o0), 1);
        flush();
        chk("clr_valid", int'(v0), 0);
        chk("clr_ovr", int'(o0), 0);
        chk("clr_data", int'(d0), 0);

        for (int i = 7; i >= 0; i--) drive(1'b1, 1'(8'h12 >> i), 2'b00, 1'b1, 1'b0);
        chk("b2b_v8", int'(v0), 1);
        chk("b2b_d8", int'(d0), 8'h12);
        for (int i = 7; i >= 0; i--) drive(1'b1, 1'(8'h34 >> i), 2'b00, 1'b1, 1'b0);
        chk("b2b_v16", int'(v0), 1);
        chk("b2b_d16", int'(d0), 8'h34);
        chk("b2b_ovr", int'(o0), 0);

        flush();
        drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
        chk("sa2_data", int'(d2), 8'hC9);
        chk("sa2_valid", int'(v2), 1);

        flush();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        chk("mid_count", int'(c0), 3);
        shift = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("arst_count", int'(c0), 0);
        chk("arst_data", int'(d0), 0);
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b1;
        send8(8'h81, 1'b0);
        chk("post_rst", int'(d0), 8'h81);
        chk("post_cnt", int'(c0), 0);

        for (int n = 0; n < 400; n++)
            drive($urandom_range(0, 9) < 7, 1'($urandom), 2'($urandom),
                  1'($urandom), $urandom_range(0, 39) == 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
